// File: rtl/mul_share_sched.sv
// Round-robin sharing of one pipelined signed multiplier among NREQ requesters, ID-tagged returns.
// Latency: accept edge E0 -> rsp_valid in the cycle after enabled edge E0+MUL_LAT; en=0 stretches it.
// Backpressure: req_ready per requester (one-hot grant, gated by en/rst); responses have none.
module mul_share_sched #(
  parameter int NREQ    = 4,
  parameter int ASIZE   = 16,
  parameter int BSIZE   = 16,
  parameter int MUL_LAT = 3,
  parameter int PSIZE   = ASIZE + BSIZE,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int IFW     = $clog2(MUL_LAT + 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*ASIZE-1:0]   req_a,
  input  logic [NREQ*BSIZE-1:0]   req_b,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [PSIZE-1:0]        rsp_p,
  output logic                    mul_ce,
  output logic [ASIZE-1:0]        mul_a,
  output logic [BSIZE-1:0]        mul_b,
  input  logic [PSIZE-1:0]        mul_p,
  output logic [IFW-1:0]          in_flight
);

  localparam int SW = IDW + 1;

  logic [IDW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [ASIZE-1:0]           mul_a_q, mul_a_d;
  logic [BSIZE-1:0]           mul_b_q, mul_b_d;
  logic [MUL_LAT:0]           tag_vld_q, tag_vld_d;
  logic [MUL_LAT:0][IDW-1:0]  tag_id_q, tag_id_d;
  logic [IFW-1:0]             in_flight_q, in_flight_d;

  logic [2*NREQ-1:0]          rot;
  logic [SW-1:0]              sum;
  logic                       gnt_vld;
  logic [IDW-1:0]             gnt_id;
  logic [ASIZE-1:0]           sel_a;
  logic [BSIZE-1:0]           sel_b;
  logic                       acc;
  logic                       ret;

  // Rotate requests so bit k is requester (rr_ptr + k) mod NREQ.
  assign rot = {req_valid, req_valid} >> rr_ptr_q;

  // Cyclic priority search from rr_ptr; lowest rotated index wins.
  always_comb begin
    gnt_vld = 1'b0;
    sum     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_vld = 1'b1;
        sum     = {1'b0, rr_ptr_q} + SW'(k);
      end
    end
    if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
    gnt_id = sum[IDW-1:0];
  end

  // An accept needs a winner, a running pipe and no reset in progress.
  assign acc = gnt_vld & en & ~rst;
  // The oldest tag leaves the pipe only on an enabled edge.
  assign ret = en & tag_vld_q[MUL_LAT];

  // Operand mux and one-hot ready/response decodes.
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    rsp_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == IDW'(k)) begin
        sel_a        = req_a[k*ASIZE +: ASIZE];
        sel_b        = req_b[k*BSIZE +: BSIZE];
        req_ready[k] = acc;
      end
      if (tag_id_q[MUL_LAT] == IDW'(k)) rsp_valid[k] = ret;
    end
  end

  // Next state: operand regs load on accept, tag pipe shifts with the multiplier.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    tag_vld_d = tag_vld_q;
    tag_id_d  = tag_id_q;
    if (acc) begin
      mul_a_d  = sel_a;
      mul_b_d  = sel_b;
      rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
    if (en) begin
      tag_vld_d = {tag_vld_q[MUL_LAT-1:0], acc};
      tag_id_d  = {tag_id_q[MUL_LAT-1:0], gnt_id};
    end
    in_flight_d = in_flight_q + IFW'(acc) - IFW'(ret);
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      in_flight_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign mul_ce    = en;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_id    = tag_id_q[MUL_LAT];
  assign rsp_p     = mul_p;
  assign in_flight = in_flight_q;

endmodule

// File: tb/tb_mul_share_sched.sv
// Bench for mul_share_sched with a behavioural 3-stage signed multiplier attached.
// Reference model: round-robin pointer plus a FIFO of expected {id, product, due enabled-edge count}.
// Directed scenarios then a randomized valid/en soak compared cycle by cycle.
module tb_mul_share_sched;
  localparam int NREQ = 4, ASIZE = 16, BSIZE = 16, MUL_LAT = 3, PSIZE = 32, IDW = 2, IFW = 3;

  logic clk = 1'b0;
  logic rst, en;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
  logic [NREQ*ASIZE-1:0] req_a;
  logic [NREQ*BSIZE-1:0] req_b;
  logic [IDW-1:0] rsp_id;
  logic [PSIZE-1:0] rsp_p, mul_p;
  logic mul_ce;
  logic [ASIZE-1:0] mul_a;
  logic [BSIZE-1:0] mul_b;
  logic [IFW-1:0] in_flight;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mul_share_sched #(.NREQ(NREQ), .ASIZE(ASIZE), .BSIZE(BSIZE), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .mul_ce(mul_ce), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .in_flight(in_flight)
  );

  // External multiplier: MUL_LAT registers, clock enable, shares rst.
  logic [PSIZE-1:0] mp [MUL_LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) mp[i] <= '0;
    end else if (mul_ce) begin
      mp[0] <= $signed(mul_a) * $signed(mul_b);
      for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_p = mp[MUL_LAT-1];

  // Reference model state.
  typedef struct { int id; logic [31:0] p; int due; } exp_t;
  exp_t q[$];
  int ptr_m;
  int en_cnt;

  function automatic int model_grant(logic [NREQ-1:0] v, int ptr);
    for (int k = 0; k < NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] ref_mul(logic [15:0] a, logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  function automatic exp_t mk(int g);
    exp_t e;
    e.id  = g;
    e.p   = ref_mul(req_a[g*ASIZE +: ASIZE], req_b[g*BSIZE +: BSIZE]);
    e.due = en_cnt + 1 + MUL_LAT;
    return e;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    if (rst || !en) return '0;
    g = model_grant(req_valid, ptr_m);
    if (g < 0) return '0;
    return NREQ'(1 << g);
  endfunction

  function automatic logic [NREQ-1:0] exp_rsp();
    if (en && q.size() > 0 && q[0].due == en_cnt) return NREQ'(1 << q[0].id);
    return '0;
  endfunction

  // Model advance on each edge: retire due head, record accept, count enabled edges.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      ptr_m  <= 0;
      en_cnt <= 0;
    end else if (en) begin
      if (q.size() > 0 && q[0].due == en_cnt) void'(q.pop_front());
      if (model_grant(req_valid, ptr_m) >= 0) begin
        q.push_back(mk(model_grant(req_valid, ptr_m)));
        ptr_m <= (model_grant(req_valid, ptr_m) + 1) % NREQ;
      end
      en_cnt <= en_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req_valid = '1;
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    @(negedge clk);
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got %h want 0", req_ready); end
    total++; if (rsp_valid !== 4'h0) begin bad++; $display("FAIL reset_rsp_valid got %h want 0", rsp_valid); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    total++; if (mul_a !== 16'h0) begin bad++; $display("FAIL reset_mul_a got %h want 0", mul_a); end
    total++; if (mul_b !== 16'h0) begin bad++; $display("FAIL reset_mul_b got %h want 0", mul_b); end
    total++; if (in_flight !== 3'd0) begin bad++; $display("FAIL reset_in_flight got %0d want 0", in_flight); end
    step();
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_a[47:32] = 16'h0003; req_b[47:32] = 16'hFFFE;
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      total++; if (rsp_valid !== ((k == 3) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL single_rsp_valid after E%0d got %b", k, rsp_valid); end
      total++; if (in_flight !== ((k <= 3) ? 3'd1 : 3'd0)) begin bad++; $display("FAIL single_in_flight after E%0d got %0d", k, in_flight); end
      if (k == 3) begin
        total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL single_rsp_id got %0d want 2", rsp_id); end
        total++; if (rsp_p !== 32'hFFFFFFFA) begin bad++; $display("FAIL single_rsp_p got %h want FFFFFFFA", rsp_p); end
      end
      step();
    end
  endtask

  task automatic test_all_valid();
    logic [31:0] prod [5];
    logic [NREQ-1:0] want;
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = '1; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      want = (k < 5) ? NREQ'(1 << (k % NREQ)) : '0;
      total++; if (req_ready !== want) begin bad++; $display("FAIL rr_ready k=%0d got %b want %b", k, req_ready, want); end
      if (k < 5) prod[k] = ref_mul(req_a[(k%NREQ)*ASIZE +: ASIZE], req_b[(k%NREQ)*BSIZE +: BSIZE]);
      want = (k >= 4 && k <= 8) ? NREQ'(1 << ((k - 4) % NREQ)) : '0;
      total++; if (rsp_valid !== want) begin bad++; $display("FAIL rr_rsp_valid k=%0d got %b want %b", k, rsp_valid, want); end
      if (k >= 4 && k <= 8) begin
        total++; if (rsp_p !== prod[k-4]) begin bad++; $display("FAIL rr_rsp_p k=%0d got %h want %h", k, rsp_p, prod[k-4]); end
      end
      step();
      if (k < 5) begin
        req_a[(k%NREQ)*ASIZE +: ASIZE] = 16'($urandom);
        req_b[(k%NREQ)*BSIZE +: BSIZE] = 16'($urandom);
      end
      if (k == 4) req_valid = '0;
    end
  endtask

  task automatic test_signed();
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic [31:0] tp [3];
    ta = '{16'h8000, 16'h8000, 16'h0000};
    tb = '{16'h8000, 16'h7FFF, 16'h1234};
    tp = '{32'h40000000, 32'hC0008000, 32'h00000000};
    for (int j = 0; j < 3; j++) begin
      req_valid = 4'b0001; req_a[15:0] = ta[j]; req_b[15:0] = tb[j];
      step();
      req_valid = '0;
      for (int k = 0; k <= 3; k++) begin
        @(negedge clk);
        if (k == 3) begin
          total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL signed%0d_valid got %b want 0001", j, rsp_valid); end
          total++; if (rsp_p !== tp[j]) begin bad++; $display("FAIL signed%0d_p got %h want %h", j, rsp_p, tp[j]); end
        end
        step();
      end
    end
  endtask

  task automatic test_stall();
    req_valid = 4'b0010; req_a[31:16] = 16'd5; req_b[31:16] = 16'hFFF9;
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL stall_accept got %b want 0010", req_ready); end
    step();
    req_valid = 4'b1000; en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL stall_ready got %b want 0", req_ready); end
      total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL stall_rsp_frozen got %b want 0", rsp_valid); end
      total++; if (in_flight !== 3'd1) begin bad++; $display("FAIL stall_in_flight got %0d want 1", in_flight); end
      step();
    end
    en = 1'b1; req_valid = '0;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      total++; if (rsp_valid !== ((k == 5) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL stall_rsp after E%0d got %b", k, rsp_valid); end
      if (k == 5) begin
        total++; if (rsp_p !== 32'hFFFFFFDD) begin bad++; $display("FAIL stall_rsp_p got %h want FFFFFFDD", rsp_p); end
      end
      step();
    end
  endtask

  task automatic test_reset_midflight();
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1; req_valid = '0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rstmid_rsp got %b want 0", rsp_valid); end
      total++; if (in_flight !== 3'd0) begin bad++; $display("FAIL rstmid_in_flight got %0d want 0", in_flight); end
      step();
    end
    req_valid = 4'b1010;
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rstmid_first_grant got %b want 0010", req_ready); end
    step();
    req_valid = '0;
  endtask

  task automatic test_soak();
    logic [NREQ-1:0] acc, er, ers;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      er = exp_ready(); ers = exp_rsp();
      total++; if (req_ready !== er) begin bad++; $display("FAIL soak_ready c=%0d got %b want %b", c, req_ready, er); end
      total++; if (rsp_valid !== ers) begin bad++; $display("FAIL soak_rsp_valid c=%0d got %b want %b", c, rsp_valid, ers); end
      if (ers != '0) begin
        total++; if (rsp_id !== 2'(q[0].id)) begin bad++; $display("FAIL soak_rsp_id c=%0d got %0d want %0d", c, rsp_id, q[0].id); end
        total++; if (rsp_p !== q[0].p) begin bad++; $display("FAIL soak_rsp_p c=%0d got %h want %h", c, rsp_p, q[0].p); end
      end
      total++; if (in_flight !== 3'(q.size())) begin bad++; $display("FAIL soak_in_flight c=%0d got %0d want %0d", c, in_flight, q.size()); end
      acc = er & req_valid;
      step();
      en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_a[i*ASIZE +: ASIZE] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
          req_b[i*BSIZE +: BSIZE] = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
        end
      end
    end
    en = 1'b1; req_valid = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ers = exp_rsp();
      total++; if (rsp_valid !== ers) begin bad++; $display("FAIL drain_rsp_valid c=%0d got %b want %b", c, rsp_valid, ers); end
      if (ers != '0) begin
        total++; if (rsp_p !== q[0].p) begin bad++; $display("FAIL drain_rsp_p c=%0d got %h want %h", c, rsp_p, q[0].p); end
      end
      step();
    end
    @(negedge clk);
    total++; if (q.size() != 0) begin bad++; $display("FAIL drain_model_empty got %0d want 0", q.size()); end
    total++; if (in_flight !== 3'd0) begin bad++; $display("FAIL drain_in_flight got %0d want 0", in_flight); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    step();
    step();
    test_reset();
    test_single();
    test_all_valid();
    test_signed();
    test_stall();
    test_reset_midflight();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_share_sched.md
# mul_share_sched

Round-robin scheduler that lets NREQ requesters share one pipelined signed multiplier (16x16, three pipeline registers, clock enable `ce`). It sits between the audio-effect engines (echo, pitch, gain) and the single multiplier instance. It accepts operand pairs over valid/ready, issues at most one pair per cycle, and tags each issue with the requester ID. It returns the product to the right requester exactly when it leaves the multiplier pipeline.

## Interface
- NREQ, 4, number of requesters (2..8)
- ASIZE, 16, operand A width
- BSIZE, 16, operand B width
- MUL_LAT, 3, multiplier pipeline registers (edges from operand to product), 1..5
- PSIZE, ASIZE+BSIZE, product width (derived)
- IDW, max(1,clog2(NREQ)), ID width (derived)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset; also drives the multiplier's rst
- en  in  1  global run enable; low freezes scheduler and multiplier
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*ASIZE  operand A, requester i at [i*ASIZE +: ASIZE]
- req_b  in  NREQ*BSIZE  operand B, requester i at [i*BSIZE +: BSIZE]
- rsp_valid  out  NREQ  one-hot product-valid strobe
- rsp_id  out  IDW  ID of requester owning rsp_p
- rsp_p  out  PSIZE  product (wired from mul_p)
- mul_ce  out  1  multiplier clock enable (= en)
- mul_a  out  ASIZE  registered operand A to multiplier
- mul_b  out  BSIZE  registered operand B to multiplier
- mul_p  in  PSIZE  multiplier product
- in_flight  out  clog2(MUL_LAT+2)  count of issued, not-yet-returned products

## Operation
- Grant is combinational. Search starts at rr_ptr and wraps cyclically; the first i with req_valid[i]=1 wins. req_ready[grant] = en. All other bits are 0.
- Accept is req_valid[i] & req_ready[i] at a clk edge. At that edge:
  - mul_a/mul_b load that requester's operands.
  - The tag pipe stage 0 loads {valid=1, id=i}.
  - rr_ptr loads (i+1) mod NREQ.
- No accept (no valid, or en=0): rr_ptr holds. mul_a/mul_b hold. Tag stage 0 loads valid=0 when en=1 and holds when en=0.
- Tag pipe depth is MUL_LAT+1 stages. It shifts only when en=1, in lockstep with the multiplier, because mul_ce=en.
- Output stage:
  - rsp_valid = onehot(last.id) & {NREQ{last.valid & en}}.
  - rsp_id = last.id.
  - rsp_p = mul_p.
- Responses have no back-pressure. Requesters must take rsp_p in the strobe cycle.
- Operands and product are treated as signed two's complement. The multiplier handles the arithmetic, and the scheduler does no width conversion. req_a/req_b bits pass to mul_a/mul_b unchanged.
- in_flight counts valid bits across all tag stages. It is updated registered and changes by at most ±1 per edge.
- Requester i must hold req_a/req_b stable while req_valid=1 and not yet accepted. Violating this is a protocol error and is not checked.

## Timing
- Reset values:
  - req_ready = 0 while rst asserted (gate grant with ~rst).
  - rsp_valid = 0, rsp_id = 0.
  - mul_a = 0, mul_b = 0.
  - All tag valids = 0, rr_ptr = 0, in_flight = 0.
- Latency: accept at edge E0 → rsp_valid high for exactly the one cycle after edge E0+MUL_LAT (sampled at E0+MUL_LAT+1). This holds with en=1 throughout.
- Throughput: one accept per enabled cycle. Sustained all-valid traffic grants 0,1,2,…,NREQ-1,0,…
- en low for k cycles: no accepts, pipeline frozen, rsp_valid forced 0. Latency stretches by exactly k. No product is duplicated or lost.
- Reset mid-operation: in-flight products are discarded and no rsp_valid is emitted for them. The first accept after rst deasserts grants the lowest valid index.
- Simultaneous issue and return in the same edge: in_flight is unchanged.
- Single requester continuously valid: it is accepted every cycle. Round-robin never starves it, and wrap from NREQ-1 to 0 is handled.

## Test plan
- Single request: req_valid[2]=1, a=0x0003, b=0xFFFE, accept at E0 → rsp_valid=4'b0100, rsp_id=2, rsp_p=0xFFFFFFFA in the cycle after E3. in_flight goes 1 then back to 0.
- All four valid continuously, rr_ptr=0 → grants 0,1,2,3,0. Responses return in the same order, one per cycle, each 4 edges after its accept.
- Signed extremes: (0x8000,0x8000) → 0x40000000; (0x8000,0x7FFF) → 0xC0008000; (0x0000,0x1234) → 0x00000000.
- Stall: accept at E0, en=0 over edges E1–E2 (two cycles) → rsp_valid appears in the cycle after E5, exactly once, with the correct product. req_ready=0 while en=0.
- Reset mid-flight: three accepts, then rst pulsed at E2 → no rsp_valid afterwards, in_flight=0. After release, with requesters 1 and 3 valid, the first grant goes to 1.
- Random soak, 10k cycles: random valid/en patterns checked against a reference model (ID-ordered FIFO of expected products). Every accepted pair returns exactly once, with the correct ID and product.
